// File: rtl/ray_dispatch_scheduler.sv
// Frame sequencer: walks pixels in raster order, issues one generator request at a
// time, captures the ray direction and hands it to a marcher core by round-robin.
//  state      | meaning
//  S_IDLE     | waiting for frame_start_in
//  S_ISSUE    | request presented to generator until gen_ready_in
//  S_WAIT_GEN | waiting for generator result
//  S_DISPATCH | offering captured ray to the first ready core from rr_ptr
//  S_DONE     | one-cycle frame_done_out pulse, then back to idle
module ray_dispatch_scheduler #(
    parameter int DISPLAY_WIDTH  = 4,
    parameter int DISPLAY_HEIGHT = 2,
    parameter int H_BITS         = 2,
    parameter int V_BITS         = 1,
    parameter int NUM_CORES      = 4,
    parameter int VEC_W          = 48
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_start_in,
    input  logic [VEC_W-1:0]     cam_pos_in,
    input  logic [VEC_W-1:0]     cam_forward_in,
    output logic                 gen_valid_out,
    input  logic                 gen_ready_in,
    output logic [H_BITS-1:0]    gen_hcount_out,
    output logic [V_BITS-1:0]    gen_vcount_out,
    output logic [VEC_W-1:0]     gen_cam_pos_out,
    output logic [VEC_W-1:0]     gen_cam_forward_out,
    input  logic                 gen_valid_in,
    input  logic [VEC_W-1:0]     gen_ray_direction_in,
    input  logic [NUM_CORES-1:0] core_ready_in,
    output logic [NUM_CORES-1:0] core_valid_out,
    output logic [H_BITS-1:0]    core_hcount_out,
    output logic [V_BITS-1:0]    core_vcount_out,
    output logic [VEC_W-1:0]     core_ray_origin_out,
    output logic [VEC_W-1:0]     core_ray_direction_out,
    output logic                 busy_out,
    output logic                 frame_done_out
);
    localparam int PTR_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_GEN, S_DISPATCH, S_DONE} state_t;

    state_t                 state;
    logic [H_BITS-1:0]      h;
    logic [V_BITS-1:0]      v;
    logic [PTR_BITS-1:0]    rr_ptr;
    logic [VEC_W-1:0]       cam_pos;
    logic [VEC_W-1:0]       cam_forward;
    logic [VEC_W-1:0]       ray_dir;
    logic                   gen_valid;
    logic                   busy;
    logic                   frame_done;

    logic [2*NUM_CORES-1:0] ready_dbl;
    logic [NUM_CORES-1:0]   ready_rot;
    logic                   grant_any;
    logic [PTR_BITS-1:0]    grant_off;
    logic [PTR_BITS:0]      grant_sum;
    logic [PTR_BITS-1:0]    grant_idx;
    logic [PTR_BITS-1:0]    next_ptr;
    logic                   last_col;
    logic                   last_pixel;

    // Rotate ready so that bit 0 corresponds to rr_ptr; the lowest set bit wins.
    assign ready_dbl = {core_ready_in, core_ready_in};
    assign ready_rot = NUM_CORES'(ready_dbl >> rr_ptr);

    always_comb begin
        grant_any = 1'b0;
        grant_off = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (ready_rot[j]) begin
                grant_any = 1'b1;
                grant_off = PTR_BITS'(j);
            end
        end
    end

    assign grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
    assign grant_idx = (grant_sum >= (PTR_BITS+1)'(NUM_CORES))
                     ? PTR_BITS'(grant_sum - (PTR_BITS+1)'(NUM_CORES))
                     : PTR_BITS'(grant_sum);
    assign next_ptr  = (grant_idx == PTR_BITS'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_BITS'(1);

    assign last_col   = (h == H_BITS'(DISPLAY_WIDTH - 1));
    assign last_pixel = last_col && (v == V_BITS'(DISPLAY_HEIGHT - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= S_IDLE;
            h           <= '0;
            v           <= '0;
            rr_ptr      <= '0;
            cam_pos     <= '0;
            cam_forward <= '0;
            ray_dir     <= '0;
            gen_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        cam_pos     <= cam_pos_in;
                        cam_forward <= cam_forward_in;
                        h           <= '0;
                        v           <= '0;
                        gen_valid   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (gen_ready_in) begin
                        gen_valid <= 1'b0;
                        state     <= S_WAIT_GEN;
                    end
                end
                S_WAIT_GEN: begin
                    if (gen_valid_in) begin
                        ray_dir <= gen_ray_direction_in;
                        state   <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (grant_any) begin
                        rr_ptr <= next_ptr;
                        if (last_col) begin
                            h <= '0;
                            v <= v + V_BITS'(1);
                        end else begin
                            h <= h + H_BITS'(1);
                        end
                        if (last_pixel) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            gen_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign gen_valid_out          = gen_valid;
    assign gen_hcount_out         = h;
    assign gen_vcount_out         = v;
    assign gen_cam_pos_out        = cam_pos;
    assign gen_cam_forward_out    = cam_forward;
    assign core_valid_out         = (state == S_DISPATCH && grant_any)
                                  ? (NUM_CORES'(1) << grant_idx) : '0;
    assign core_hcount_out        = h;
    assign core_vcount_out        = v;
    assign core_ray_origin_out    = cam_pos;
    assign core_ray_direction_out = ray_dir;
    assign busy_out               = busy;
    assign frame_done_out         = frame_done;
endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Bench for ray_dispatch_scheduler: a latency-configurable generator model and a
// negedge monitor log transfers; each test task compares the logs to a raster/RR model.
module tb_ray_dispatch_scheduler;
    localparam int W = 4, H = 2, N = 4, VW = 48, HB = 2, VB = 1, NPIX = W * H;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          frame_start_in = 1'b0;
    logic [VW-1:0] cam_pos_in = '0;
    logic [VW-1:0] cam_forward_in = '0;
    logic          gen_valid_out;
    logic          gen_ready_in = 1'b1;
    logic [HB-1:0] gen_hcount_out;
    logic [VB-1:0] gen_vcount_out;
    logic [VW-1:0] gen_cam_pos_out;
    logic [VW-1:0] gen_cam_forward_out;
    logic          gen_valid_in = 1'b0;
    logic [VW-1:0] gen_ray_direction_in = '0;
    logic [N-1:0]  core_ready_in = '1;
    logic [N-1:0]  core_valid_out;
    logic [HB-1:0] core_hcount_out;
    logic [VB-1:0] core_vcount_out;
    logic [VW-1:0] core_ray_origin_out;
    logic [VW-1:0] core_ray_direction_out;
    logic          busy_out;
    logic          frame_done_out;

    ray_dispatch_scheduler #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB),
                             .NUM_CORES(N), .VEC_W(VW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in),
        .cam_pos_in(cam_pos_in), .cam_forward_in(cam_forward_in),
        .gen_valid_out(gen_valid_out), .gen_ready_in(gen_ready_in),
        .gen_hcount_out(gen_hcount_out), .gen_vcount_out(gen_vcount_out),
        .gen_cam_pos_out(gen_cam_pos_out), .gen_cam_forward_out(gen_cam_forward_out),
        .gen_valid_in(gen_valid_in), .gen_ray_direction_in(gen_ray_direction_in),
        .core_ready_in(core_ready_in), .core_valid_out(core_valid_out),
        .core_hcount_out(core_hcount_out), .core_vcount_out(core_vcount_out),
        .core_ray_origin_out(core_ray_origin_out), .core_ray_direction_out(core_ray_direction_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out));

    always #5 clk_in = ~clk_in;

    typedef struct { int core; int h; int v; logic [VW-1:0] org; logic [VW-1:0] dir; int cyc; } disp_t;
    typedef struct { int h; int v; int waits; bit stable; } iss_t;

    disp_t         disp_q[$];
    iss_t          iss_q[$];
    logic [VW-1:0] gen_dirs[$];
    int            done_q[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int gen_lat = 6, gen_cnt = 0;
    bit gen_hold = 0;
    logic [N-1:0] core_pat = '1;
    int stall_at = -1, stall_left = 0;
    bit stall_done = 0;
    int block_at = -1, block_left = 0, block_pos = -1, block_strobe = 0, block_unstable = 0;
    int onehot_err = 0;
    int model_rr = 0;
    int iss_wait = 0, iss_h = 0, iss_v = 0;
    bit iss_open = 0, iss_stable = 0;
    logic [VW-1:0] snap_dir;
    int snap_h, snap_v;
    disp_t d;
    iss_t  r;

    // Generator/core-side model: inputs change at negedge, transfers are read #1 later.
    always @(negedge clk_in) begin
        cyc++;
        if (!rst_n_in) begin
            gen_cnt = 0; gen_valid_in = 1'b0; iss_open = 0; iss_wait = 0;
            block_left = 0; stall_left = 0;
        end else if (gen_cnt > 0) begin
            gen_cnt--;
            if (gen_cnt == 0) begin
                gen_ray_direction_in = VW'({$urandom(), $urandom()});
                gen_valid_in = 1'b1;
                gen_dirs.push_back(gen_ray_direction_in);
                if (gen_dirs.size() == block_at + 1) begin block_left = 6; block_pos = -1; end
            end
        end else if (!gen_hold) begin
            gen_valid_in = 1'b0;
        end
        if (gen_valid_out && iss_wait == 0 && !stall_done && iss_q.size() == stall_at) begin
            stall_left = 3; stall_done = 1;
        end
        if (gen_valid_out && stall_left > 0) begin gen_ready_in = 1'b0; stall_left--; end
        else gen_ready_in = 1'b1;
        if (block_left > 0) begin core_ready_in = '0; block_left--; block_pos++; end
        else begin core_ready_in = core_pat; block_pos = -1; end
        #1;
        if (rst_n_in) begin
            if (gen_valid_out) begin
                if (!iss_open) begin
                    iss_h = int'(gen_hcount_out); iss_v = int'(gen_vcount_out);
                    iss_stable = 1; iss_open = 1;
                end else if (int'(gen_hcount_out) != iss_h || int'(gen_vcount_out) != iss_v) begin
                    iss_stable = 0;
                end
                if (gen_ready_in) begin
                    r.h = iss_h; r.v = iss_v; r.waits = iss_wait; r.stable = iss_stable;
                    iss_q.push_back(r);
                    iss_wait = 0; iss_open = 0;
                    gen_valid_in = 1'b0; gen_cnt = gen_lat;
                end else begin
                    iss_wait++;
                end
            end
            if (core_valid_out != '0) begin
                if (!$onehot(core_valid_out)) onehot_err++;
                d.core = -1;
                for (int i = 0; i < N; i++) if (core_valid_out[i] && d.core < 0) d.core = i;
                d.h = int'(core_hcount_out); d.v = int'(core_vcount_out);
                d.org = core_ray_origin_out; d.dir = core_ray_direction_out; d.cyc = cyc;
                disp_q.push_back(d);
            end
            if (frame_done_out) done_q.push_back(cyc);
            if (block_pos >= 0) begin
                if (core_valid_out != '0) block_strobe++;
                if (block_pos == 1) begin
                    snap_dir = core_ray_direction_out;
                    snap_h = int'(core_hcount_out); snap_v = int'(core_vcount_out);
                end else if (block_pos > 1 && (snap_dir !== core_ray_direction_out ||
                         snap_h != int'(core_hcount_out) || snap_v != int'(core_vcount_out))) begin
                    block_unstable++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #2;
    endtask

    function automatic int model_grant(input int ptr, input logic [N-1:0] pat);
        for (int k = 0; k < N; k++) if (pat[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic run_frame(input string tag, input int lat, input bit hold, input logic [N-1:0] pat,
                             input int stall_idx, input int block_idx, input int restart_at);
        logic [VW-1:0] p, f;
        int n, g, exp_wait;
        gen_lat = lat; gen_hold = hold; core_pat = pat;
        stall_at = stall_idx; stall_done = 0; block_at = block_idx;
        block_strobe = 0; block_unstable = 0; onehot_err = 0;
        disp_q.delete(); iss_q.delete(); gen_dirs.delete(); done_q.delete();
        p = VW'({$urandom(), $urandom()});
        f = VW'({$urandom(), $urandom()});
        frame_start_in = 1'b1; cam_pos_in = p; cam_forward_in = f;
        tick();
        frame_start_in = 1'b0; cam_pos_in = ~p; cam_forward_in = ~f;
        checks++;
        if (busy_out !== 1'b1) begin failures++; $display("FAIL %s_busy_start got=%b want=1", tag, busy_out); end
        checks++;
        if (gen_cam_pos_out !== p || gen_cam_forward_out !== f) begin
            failures++; $display("FAIL %s_cam_latch got=%h/%h want=%h/%h", tag, gen_cam_pos_out, gen_cam_forward_out, p, f);
        end
        n = 0;
        while (done_q.size() == 0 && n < 2000) begin
            if (n == restart_at) begin frame_start_in = 1'b1; cam_pos_in = p ^ 48'h1; end
            else frame_start_in = 1'b0;
            tick(); n++;
        end
        frame_start_in = 1'b0;
        checks++;
        if (done_q.size() == 0) begin failures++; $display("FAIL %s_done_timeout got=none want=pulse", tag); end
        else if (disp_q.size() > 0) begin
            checks++;
            if (done_q[0] != disp_q[disp_q.size()-1].cyc + 1) begin
                failures++; $display("FAIL %s_done_timing got=%0d want=%0d", tag, done_q[0], disp_q[disp_q.size()-1].cyc + 1);
            end
            checks++;
            if (busy_out !== 1'b1 || frame_done_out !== 1'b1) begin
                failures++; $display("FAIL %s_done_state busy=%b done=%b want=1/1", tag, busy_out, frame_done_out);
            end
        end
        checks++;
        if (disp_q.size() != NPIX || gen_dirs.size() != NPIX || iss_q.size() != NPIX) begin
            failures++; $display("FAIL %s_counts disp=%0d gen=%0d iss=%0d want=%0d", tag, disp_q.size(), gen_dirs.size(), iss_q.size(), NPIX);
        end
        checks++;
        if (onehot_err != 0) begin failures++; $display("FAIL %s_onehot got=%0d want=0", tag, onehot_err); end
        for (int k = 0; k < disp_q.size() && k < NPIX; k++) begin
            g = model_grant(model_rr, pat);
            model_rr = (g + 1) % N;
            checks++;
            if (disp_q[k].h != k % W || disp_q[k].v != k / W) begin
                failures++; $display("FAIL %s_pixel[%0d] got=(%0d,%0d) want=(%0d,%0d)", tag, k, disp_q[k].h, disp_q[k].v, k % W, k / W);
            end
            checks++;
            if (disp_q[k].core != g) begin failures++; $display("FAIL %s_core[%0d] got=%0d want=%0d", tag, k, disp_q[k].core, g); end
            checks++;
            if (disp_q[k].org !== p) begin failures++; $display("FAIL %s_origin[%0d] got=%h want=%h", tag, k, disp_q[k].org, p); end
            if (k < gen_dirs.size()) begin
                checks++;
                if (disp_q[k].dir !== gen_dirs[k]) begin
                    failures++; $display("FAIL %s_dir[%0d] got=%h want=%h", tag, k, disp_q[k].dir, gen_dirs[k]);
                end
            end
        end
        for (int k = 0; k < iss_q.size() && k < NPIX; k++) begin
            exp_wait = (k == stall_idx) ? 3 : 0;
            checks++;
            if (iss_q[k].h != k % W || iss_q[k].v != k / W || iss_q[k].waits != exp_wait || !iss_q[k].stable) begin
                failures++; $display("FAIL %s_issue[%0d] got=(%0d,%0d) waits=%0d stable=%0d want=(%0d,%0d) waits=%0d stable=1",
                                     tag, k, iss_q[k].h, iss_q[k].v, iss_q[k].waits, iss_q[k].stable, k % W, k / W, exp_wait);
            end
        end
        if (block_idx >= 0) begin
            checks++;
            if (block_strobe != 0 || block_unstable != 0) begin
                failures++; $display("FAIL %s_core_hold strobes=%0d unstable=%0d want=0/0", tag, block_strobe, block_unstable);
            end
        end
        tick();
        checks++;
        if (busy_out !== 1'b0 || frame_done_out !== 1'b0) begin
            failures++; $display("FAIL %s_idle_after busy=%b done=%b want=0/0", tag, busy_out, frame_done_out);
        end
        if (restart_at >= 0) begin
            repeat (10) tick();
            checks++;
            if (busy_out !== 1'b0 || done_q.size() != 1) begin
                failures++; $display("FAIL %s_no_requeue busy=%b dones=%0d want=0/1", tag, busy_out, done_q.size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (3) tick();
        rst_n_in = 1'b1;
        tick();
        model_rr = 0;
        checks++;
        if (gen_valid_out !== 1'b0 || core_valid_out !== '0 || busy_out !== 1'b0 || frame_done_out !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b/%b/%b/%b want=0/0/0/0", gen_valid_out, core_valid_out, busy_out, frame_done_out);
        end
        checks++;
        if (gen_hcount_out !== '0 || gen_vcount_out !== '0 || gen_cam_pos_out !== '0 || core_ray_direction_out !== '0) begin
            failures++; $display("FAIL reset_data got=%0d/%0d/%h/%h want=0", gen_hcount_out, gen_vcount_out, gen_cam_pos_out, core_ray_direction_out);
        end
    endtask

    task automatic test_round_robin();
        run_frame("rr", 2, 0, 4'b1010, -1, -1, -1);
        if (disp_q.size() >= 3) begin
            checks++;
            if (disp_q[0].core != 1 || disp_q[1].core != 3 || disp_q[2].core != 1) begin
                failures++; $display("FAIL rr_first_three got=%0d,%0d,%0d want=1,3,1", disp_q[0].core, disp_q[1].core, disp_q[2].core);
            end
        end
    endtask

    task automatic test_raster();     run_frame("raster", 6, 0, 4'b1111, -1, -1, -1); endtask
    task automatic test_core_stall(); run_frame("core_stall", 3, 0, 4'b1111, -1, 2, -1); endtask
    task automatic test_gen_hold();   run_frame("gen_hold", $urandom_range(1, 6), 1, 4'b1111, -1, -1, -1); endtask
    task automatic test_gen_stall();  run_frame("gen_stall", 2, 0, 4'b0110, 2, -1, -1); endtask
    task automatic test_ignored_start(); run_frame("ignored_start", 4, 1, 4'b1111, -1, -1, 20); endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++)
            run_frame("random", $urandom_range(1, 6), 1'($urandom_range(0, 1)), N'($urandom_range(1, 15)),
                      $urandom_range(0, NPIX - 1), -1, -1);
    endtask

    task automatic test_reset_midframe();
        int n;
        gen_lat = 6; gen_hold = 0; core_pat = '1; stall_at = -1; block_at = -1;
        disp_q.delete(); iss_q.delete(); gen_dirs.delete(); done_q.delete();
        frame_start_in = 1'b1; cam_pos_in = VW'({$urandom(), $urandom()});
        tick();
        frame_start_in = 1'b0;
        n = 0;
        while (iss_q.size() < 3 && n < 500) begin tick(); n++; end
        checks++;
        if (iss_q.size() < 3) begin failures++; $display("FAIL midrst_reach got=%0d want=3", iss_q.size()); end
        else begin
            checks++;
            if (iss_q[2].h != 2 || iss_q[2].v != 0) begin
                failures++; $display("FAIL midrst_pixel got=(%0d,%0d) want=(2,0)", iss_q[2].h, iss_q[2].v);
            end
        end
        tick();
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (busy_out !== 1'b0 || gen_valid_out !== 1'b0 || core_valid_out !== '0 || frame_done_out !== 1'b0 ||
            gen_hcount_out !== '0 || core_ray_origin_out !== '0 || core_ray_direction_out !== '0) begin
            failures++; $display("FAIL midrst_async busy=%b gv=%b cv=%b fd=%b h=%0d org=%h dir=%h want=all 0",
                                 busy_out, gen_valid_out, core_valid_out, frame_done_out, gen_hcount_out,
                                 core_ray_origin_out, core_ray_direction_out);
        end
        repeat (2) tick();
        rst_n_in = 1'b1;
        model_rr = 0;
        repeat (10) tick();
        checks++;
        if (done_q.size() != 0 || busy_out !== 1'b0) begin
            failures++; $display("FAIL midrst_no_done dones=%0d busy=%b want=0/0", done_q.size(), busy_out);
        end
        run_frame("after_rst", 6, 0, 4'b1111, -1, -1, -1);
        if (disp_q.size() > 0) begin
            checks++;
            if (disp_q[0].core != 0 || disp_q[0].h != 0 || disp_q[0].v != 0) begin
                failures++; $display("FAIL midrst_restart got=core%0d (%0d,%0d) want=core0 (0,0)", disp_q[0].core, disp_q[0].h, disp_q[0].v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_raster();
        test_core_stall();
        test_gen_hold();
        test_gen_stall();
        test_ignored_start();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
